// File: rtl/cpu_if.sv
// Memory port of the Sigma-subset CPU: 17-bit word address out, 32-bit read data back.
// Bit 0 is the most significant bit on both buses.
interface cpu_if;
  logic [15:31] address;
  logic [0:31]  mem_data;

  modport master (output address, input  mem_data);
  modport slave  (input  address, output mem_data);
endinterface

// File: rtl/cpu.sv
// Read-only subset of the Xerox Sigma CPU: fetch / execute (optional indirect) / halt on WAIT.
// Define CPU_INDIRECT_EN to enable the indirect-address phase; by default bit 0 is ignored.
module cpu #(
  parameter logic [15:31] RESET_PC = 17'h00000
) (
  input  logic  clock,
  input  logic  reset,
  cpu_if.master bus
);

`ifdef CPU_INDIRECT_EN
  localparam logic IND_EN = 1'b1;
`else
  localparam logic IND_EN = 1'b0;
`endif

  localparam logic [0:6] OP_AI   = 7'h20;
  localparam logic [0:6] OP_LI   = 7'h22;
  localparam logic [0:6] OP_WAIT = 7'h2E;
  localparam logic [0:6] OP_AW   = 7'h30;
  localparam logic [0:6] OP_CW   = 7'h31;
  localparam logic [0:6] OP_LW   = 7'h32;
  localparam logic [0:6] OP_BCR  = 7'h68;
  localparam logic [0:6] OP_BCS  = 7'h69;

  typedef enum logic [1:0] {
    PH_FETCH = 2'd0,
    PH_EXEC  = 2'd1,
    PH_IND   = 2'd2,
    PH_HALT  = 2'd3
  } phase_t;

  phase_t        phase_r;
  logic [15:31]  p_r;
  logic [0:31]   c_r;
  logic [0:6]    o;
  logic          ende;
  logic [0:31]   gpr_r [0:15];
  logic [1:4]    cc_r;
  logic [15:31]  ind_ea_r;

  logic [0:6]    op_s;
  logic [0:3]    r_s;
  logic [0:2]    x_s;
  logic [0:31]   imm_s;
  logic [0:31]   rval_s;
  logic [15:31]  index_s;
  logic [15:31]  ea_s;
  logic [15:31]  eff_ea_s;
  logic [0:31]   operand_s;
  logic [32:0]   sum_s;
  logic [0:31]   add_res_s;
  logic          add_ovf_s;
  logic          cmp_gt_s;
  logic          cmp_lt_s;
  logic          wr_en_s;
  logic [0:31]   res_s;
  logic [1:4]    cc_upd_s;
  logic          br_take_s;
  logic [15:31]  addr_s;

  // Branches and memory-reference ops all use the effective address.
  function automatic logic is_ea_op(input logic [0:6] op);
    return (op == OP_LW) || (op == OP_AW) || (op == OP_CW) ||
           (op == OP_BCR) || (op == OP_BCS);
  endfunction

  // {result > 0, result < 0} for a signed 32-bit value.
  function automatic logic [0:1] sign_flags(input logic [0:31] v);
    return {(!v[0] && (v != 32'h00000000)), v[0]};
  endfunction

  assign op_s      = c_r[1:7];
  assign r_s       = c_r[8:11];
  assign x_s       = c_r[12:14];
  assign imm_s     = {{12{c_r[12]}}, c_r[12:31]};
  assign rval_s    = gpr_r[r_s];
  assign index_s   = (x_s != 3'd0) ? gpr_r[x_s][15:31] : 17'h00000;
  assign ea_s      = c_r[15:31] + index_s;
  // Indexing happened before the pointer was fetched, so the IND result is used as-is.
  assign eff_ea_s  = (IND_EN && c_r[0]) ? ind_ea_r : ea_s;
  assign operand_s = (op_s == OP_AI) ? imm_s : bus.mem_data;
  assign sum_s     = {1'b0, rval_s} + {1'b0, operand_s};
  assign add_res_s = sum_s[31:0];
  assign add_ovf_s = (rval_s[0] == operand_s[0]) && (add_res_s[0] != rval_s[0]);
  assign cmp_gt_s  = $signed(rval_s) > $signed(bus.mem_data);
  assign cmp_lt_s  = $signed(rval_s) < $signed(bus.mem_data);

  // Execute-cycle datapath: register write value, new condition code, branch decision.
  always_comb begin
    wr_en_s   = 1'b0;
    res_s     = 32'h00000000;
    cc_upd_s  = cc_r;
    br_take_s = 1'b0;
    case (op_s)
      OP_LI: begin
        wr_en_s  = 1'b1;
        res_s    = imm_s;
        cc_upd_s = {2'b00, sign_flags(imm_s)};
      end
      OP_AI, OP_AW: begin
        wr_en_s  = 1'b1;
        res_s    = add_res_s;
        cc_upd_s = {sum_s[32], add_ovf_s, sign_flags(add_res_s)};
      end
      OP_LW: begin
        wr_en_s  = 1'b1;
        res_s    = bus.mem_data;
        cc_upd_s = {2'b00, sign_flags(bus.mem_data)};
      end
      OP_CW: begin
        cc_upd_s = {cc_r[1:2], cmp_gt_s, cmp_lt_s};
      end
      OP_BCR: begin
        br_take_s = ((cc_r & r_s) == 4'h0);
      end
      OP_BCS: begin
        br_take_s = ((cc_r & r_s) != 4'h0);
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Memory address: pointer during IND, EA while executing an EA op, else the PC.
  always_comb begin
    if (phase_r == PH_IND) begin
      addr_s = ea_s;
    end else if (ende && is_ea_op(o)) begin
      addr_s = eff_ea_s;
    end else begin
      addr_s = p_r;
    end
  end

  assign bus.address = addr_s;

  // Phase sequencer and all architectural state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_r  <= PH_FETCH;
      p_r      <= RESET_PC;
      c_r      <= 32'h00000000;
      o        <= 7'h00;
      ende     <= 1'b0;
      cc_r     <= 4'h0;
      ind_ea_r <= 17'h00000;
      for (int i = 0; i < 16; i++) begin
        gpr_r[i] <= 32'h00000000;
      end
    end else begin
      case (phase_r)
        PH_FETCH: begin
          c_r <= bus.mem_data;
          o   <= bus.mem_data[1:7];
          p_r <= p_r + 17'd1;
          if (IND_EN && bus.mem_data[0] && is_ea_op(bus.mem_data[1:7])) begin
            phase_r <= PH_IND;
            ende    <= 1'b0;
          end else begin
            phase_r <= PH_EXEC;
            ende    <= 1'b1;
          end
        end
        PH_IND: begin
          ind_ea_r <= bus.mem_data[15:31];
          phase_r  <= PH_EXEC;
          ende     <= 1'b1;
        end
        PH_EXEC: begin
          if (wr_en_s) begin
            gpr_r[r_s] <= res_s;
          end
          cc_r <= cc_upd_s;
          if (br_take_s) begin
            p_r <= eff_ea_s;
          end
          ende    <= 1'b0;
          phase_r <= (op_s == OP_WAIT) ? PH_HALT : PH_FETCH;
        end
        PH_HALT: begin
          ende <= 1'b0;
        end
        default: begin
          phase_r <= PH_FETCH;
          ende    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Directed self-checking bench for cpu: small programs in a 512-word memory model,
// each scenario checking registers, condition codes, address bus and cycle counts.
module tb_cpu;
  logic clock = 1'b1;
  logic reset = 1'b1;
  logic [0:31] mem [0:511];
  int n_vec = 0;
  int n_err = 0;

  cpu_if bus ();

  cpu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  assign bus.mem_data = mem[bus.address[23:31]];

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 32'h00000000;
  endtask

  task automatic hold_reset();
    @(negedge clock);
    reset = 1'b0;
    clear_mem();
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Clocks until o==0x2E; counts edges and the ende pulses seen before WAIT is loaded.
  task automatic run_halt(output int edges, output int endes, output bit hit);
    edges = 0;
    endes = 0;
    hit   = 1'b0;
    while (!hit && edges < 200) begin
      @(posedge clock);
      #1;
      edges++;
      if (dut.o == 7'h2E) hit = 1'b1;
      else if (dut.ende) endes++;
    end
  endtask

  task automatic test_reset();
    int e, d;
    bit h;
    clear_mem();
    mem[0] = 32'h22100005;
    mem[1] = 32'h2E000000;
    #25 reset = 1'b0;
    #1;
    n_vec++; if (bus.address !== 17'h00000) begin n_err++; $display("FAIL rst_addr: got %h expected 00000", bus.address); end
    n_vec++; if (dut.o !== 7'h00) begin n_err++; $display("FAIL rst_o: got %h expected 00", dut.o); end
    n_vec++; if (dut.ende !== 1'b0) begin n_err++; $display("FAIL rst_ende: got %b expected 0", dut.ende); end
    n_vec++; if (dut.gpr_r[1] !== 32'h00000000) begin n_err++; $display("FAIL rst_r1: got %h expected 00000000", dut.gpr_r[1]); end
    n_vec++; if (dut.cc_r !== 4'b0000) begin n_err++; $display("FAIL rst_cc: got %b expected 0000", dut.cc_r); end
    #89 reset = 1'b1;
    run_halt(e, d, h);
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL li_halt: WAIT not reached within 200 cycles"); end
    // LI fetch, LI exec, then the third edge loads WAIT.
    n_vec++; if (e !== 3) begin n_err++; $display("FAIL li_edges: got %0d expected 3", e); end
    n_vec++; if (d !== 1) begin n_err++; $display("FAIL li_endes: got %0d expected 1", d); end
    n_vec++; if (dut.gpr_r[1] !== 32'h00000005) begin n_err++; $display("FAIL li_r1: got %h expected 00000005", dut.gpr_r[1]); end
    n_vec++; if (dut.cc_r !== 4'b0010) begin n_err++; $display("FAIL li_cc: got %b expected 0010", dut.cc_r); end
    step(3);
    n_vec++; if (bus.address !== 17'h00002) begin n_err++; $display("FAIL halt_addr: got %h expected 00002", bus.address); end
    n_vec++; if (dut.ende !== 1'b0) begin n_err++; $display("FAIL halt_ende: got %b expected 0", dut.ende); end
    n_vec++; if (dut.o !== 7'h2E) begin n_err++; $display("FAIL halt_o: got %h expected 2e", dut.o); end
  endtask

  task automatic test_add_carry();
    int e, d;
    bit h;
    hold_reset();
    mem[0] = 32'h222FFFFF;
    mem[1] = 32'h20200001;
    mem[2] = 32'h2E000000;
    release_reset();
    step(2);
    n_vec++; if (dut.gpr_r[2] !== 32'hFFFFFFFF) begin n_err++; $display("FAIL li_neg_r2: got %h expected ffffffff", dut.gpr_r[2]); end
    n_vec++; if (dut.cc_r !== 4'b0001) begin n_err++; $display("FAIL li_neg_cc: got %b expected 0001", dut.cc_r); end
    run_halt(e, d, h);
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL ai_halt: WAIT not reached within 200 cycles"); end
    n_vec++; if (e !== 3) begin n_err++; $display("FAIL ai_edges: got %0d expected 3", e); end
    n_vec++; if (dut.gpr_r[2] !== 32'h00000000) begin n_err++; $display("FAIL ai_r2: got %h expected 00000000", dut.gpr_r[2]); end
    n_vec++; if (dut.cc_r !== 4'b1000) begin n_err++; $display("FAIL ai_cc: got %b expected 1000", dut.cc_r); end
  endtask

  task automatic test_load();
    int e, d;
    bit h;
    hold_reset();
    mem[0]     = 32'h32300040;
    mem[1]     = 32'h2E000000;
    mem[9'h40] = 32'h12345678;
    release_reset();
    step(1);
    n_vec++; if (bus.address !== 17'h00040) begin n_err++; $display("FAIL lw_addr: got %h expected 00040", bus.address); end
    n_vec++; if (dut.ende !== 1'b1) begin n_err++; $display("FAIL lw_ende: got %b expected 1", dut.ende); end
    n_vec++; if (dut.o !== 7'h32) begin n_err++; $display("FAIL lw_o: got %h expected 32", dut.o); end
    run_halt(e, d, h);
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL lw_halt: WAIT not reached within 200 cycles"); end
    n_vec++; if (dut.gpr_r[3] !== 32'h12345678) begin n_err++; $display("FAIL lw_r3: got %h expected 12345678", dut.gpr_r[3]); end
    n_vec++; if (dut.cc_r !== 4'b0010) begin n_err++; $display("FAIL lw_cc: got %b expected 0010", dut.cc_r); end
  endtask

  task automatic test_overflow();
    int e, d;
    bit h;
    hold_reset();
    mem[0]     = 32'h32100041;
    mem[1]     = 32'h30100040;
    mem[2]     = 32'h2E000000;
    mem[9'h40] = 32'h00000001;
    mem[9'h41] = 32'h7FFFFFFF;
    release_reset();
    run_halt(e, d, h);
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL aw_halt: WAIT not reached within 200 cycles"); end
    n_vec++; if (e !== 5) begin n_err++; $display("FAIL aw_edges: got %0d expected 5", e); end
    n_vec++; if (d !== 2) begin n_err++; $display("FAIL aw_endes: got %0d expected 2", d); end
    n_vec++; if (dut.gpr_r[1] !== 32'h80000000) begin n_err++; $display("FAIL aw_r1: got %h expected 80000000", dut.gpr_r[1]); end
    n_vec++; if (dut.cc_r !== 4'b0101) begin n_err++; $display("FAIL aw_cc: got %b expected 0101", dut.cc_r); end
  endtask

  task automatic test_indexed();
    int e, d;
    bit h;
    hold_reset();
    mem[0]     = 32'h22100002;
    mem[1]     = 32'h32420040;
    mem[2]     = 32'h2E000000;
    mem[9'h42] = 32'hA5A50042;
    release_reset();
    step(3);
    n_vec++; if (bus.address !== 17'h00042) begin n_err++; $display("FAIL idx_addr: got %h expected 00042", bus.address); end
    run_halt(e, d, h);
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL idx_halt: WAIT not reached within 200 cycles"); end
    n_vec++; if (dut.gpr_r[4] !== 32'hA5A50042) begin n_err++; $display("FAIL idx_r4: got %h expected a5a50042", dut.gpr_r[4]); end
    n_vec++; if (dut.cc_r !== 4'b0001) begin n_err++; $display("FAIL idx_cc: got %b expected 0001", dut.cc_r); end
  endtask

  task automatic test_compare_branch();
    int e, d;
    bit h;
    hold_reset();
    mem[0]     = 32'h22100003;
    mem[1]     = 32'h31100040;
    mem[2]     = 32'h69100005;
    mem[3]     = 32'h22200007;
    mem[4]     = 32'h2E000000;
    mem[5]     = 32'h22200009;
    mem[6]     = 32'h68100008;
    mem[7]     = 32'h22300001;
    mem[8]     = 32'h2E000000;
    mem[9'h40] = 32'h00000005;
    release_reset();
    step(4);
    n_vec++; if (dut.cc_r !== 4'b0001) begin n_err++; $display("FAIL cw_cc: got %b expected 0001", dut.cc_r); end
    run_halt(e, d, h);
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL br_halt: WAIT not reached within 200 cycles"); end
    n_vec++; if (e !== 7) begin n_err++; $display("FAIL br_edges: got %0d expected 7", e); end
    n_vec++; if (d !== 3) begin n_err++; $display("FAIL br_endes: got %0d expected 3", d); end
    n_vec++; if (dut.gpr_r[2] !== 32'h00000009) begin n_err++; $display("FAIL br_r2: got %h expected 00000009", dut.gpr_r[2]); end
    n_vec++; if (dut.gpr_r[3] !== 32'h00000000) begin n_err++; $display("FAIL br_r3: got %h expected 00000000", dut.gpr_r[3]); end
    n_vec++; if (dut.cc_r !== 4'b0010) begin n_err++; $display("FAIL br_cc: got %b expected 0010", dut.cc_r); end
    step(1);
    n_vec++; if (bus.address !== 17'h00009) begin n_err++; $display("FAIL br_haltaddr: got %h expected 00009", bus.address); end
  endtask

  task automatic test_noop();
    int e, d;
    bit h;
    hold_reset();
    mem[0] = 32'h22100005;
    mem[1] = 32'h7F1FFFFF;
    mem[2] = 32'h2E000000;
    release_reset();
    run_halt(e, d, h);
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL nop_halt: WAIT not reached within 200 cycles"); end
    n_vec++; if (d !== 2) begin n_err++; $display("FAIL nop_endes: got %0d expected 2", d); end
    n_vec++; if (dut.gpr_r[1] !== 32'h00000005) begin n_err++; $display("FAIL nop_r1: got %h expected 00000005", dut.gpr_r[1]); end
    n_vec++; if (dut.cc_r !== 4'b0010) begin n_err++; $display("FAIL nop_cc: got %b expected 0010", dut.cc_r); end
  endtask

  task automatic test_indirect_bit();
    int e, d;
    bit h;
    hold_reset();
    mem[0]     = 32'hB2300040;
    mem[1]     = 32'h2E000000;
    mem[9'h40] = 32'h00000050;
    mem[9'h50] = 32'hCAFEF00D;
    release_reset();
    run_halt(e, d, h);
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL ind_halt: WAIT not reached within 200 cycles"); end
`ifdef CPU_INDIRECT_EN
    n_vec++; if (e !== 4) begin n_err++; $display("FAIL ind_edges: got %0d expected 4", e); end
    n_vec++; if (dut.gpr_r[3] !== 32'hCAFEF00D) begin n_err++; $display("FAIL ind_r3: got %h expected cafef00d", dut.gpr_r[3]); end
`else
    n_vec++; if (e !== 3) begin n_err++; $display("FAIL ind_edges: got %0d expected 3", e); end
    n_vec++; if (dut.gpr_r[3] !== 32'h00000050) begin n_err++; $display("FAIL ind_r3: got %h expected 00000050", dut.gpr_r[3]); end
`endif
  endtask

  task automatic test_branch_loop();
    hold_reset();
    mem[0] = 32'h68000000;
    mem[1] = 32'h2E000000;
    release_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1);
      n_vec++; if (bus.address !== 17'h00000) begin n_err++; $display("FAIL loop_addr%0d: got %h expected 00000", i, bus.address); end
      n_vec++; if (dut.ende !== (i % 2 == 1)) begin n_err++; $display("FAIL loop_ende%0d: got %b expected %b", i, dut.ende, (i % 2 == 1)); end
    end
    #2 reset = 1'b0;
    #1;
    n_vec++; if (dut.ende !== 1'b0) begin n_err++; $display("FAIL loop_rst_ende: got %b expected 0", dut.ende); end
    n_vec++; if (dut.o !== 7'h00) begin n_err++; $display("FAIL loop_rst_o: got %h expected 00", dut.o); end
  endtask

  task automatic test_async_reset();
    hold_reset();
    mem[0]     = 32'h32300040;
    mem[9'h40] = 32'h0BADF00D;
    release_reset();
    step(1);
    n_vec++; if (bus.address !== 17'h00040) begin n_err++; $display("FAIL ar_pre_addr: got %h expected 00040", bus.address); end
    // Drop reset mid-EXEC, well away from any clock edge.
    #2 reset = 1'b0;
    #1;
    n_vec++; if (bus.address !== 17'h00000) begin n_err++; $display("FAIL ar_addr: got %h expected 00000", bus.address); end
    n_vec++; if (dut.o !== 7'h00) begin n_err++; $display("FAIL ar_o: got %h expected 00", dut.o); end
    n_vec++; if (dut.gpr_r[3] !== 32'h00000000) begin n_err++; $display("FAIL ar_r3: got %h expected 00000000", dut.gpr_r[3]); end
    release_reset();
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_load();
    test_overflow();
    test_indexed();
    test_compare_branch();
    test_noop();
    test_indirect_bit();
    test_branch_loop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
